mips_program_loader: RTL
========================

# mips_program_loader

Upstream boot stage for the single-cycle MIPS core. Accepts a program as a byte stream over a valid/ready handshake, packs bytes into 32-bit little-endian words and writes them sequentially into instruction memory from address 0. Holds the core in reset until the programmed word count is written, then releases it.

## Interface
Parameters:
- ADDR_W, 8: instruction-memory word-address width. Capacity is 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Sampled in IDLE and DONE only.
- word_count  in  ADDR_W+1  number of words to load. Sampled on the accepted start.
- in_data  in  8  program byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  packed word.
- cpu_rst  out  1  active-high reset to the MIPS core.
- busy  out  1  load in progress (RECV or WRITE).
- done  out  1  load complete; core released.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: cpu_rst=1 and in_ready=0. start with word_count=0 goes to DONE. start with word_count>0 clears the byte counter and word address, latches the count, and goes to RECV.
- Count clamp: counts above 2^ADDR_W are clamped to 2^ADDR_W.
- RECV: in_ready=1. Each handshake (in_valid & in_ready at a rising edge) shifts in one byte. Byte k of a word (k=0..3) goes to bits [8k+7:8k], so the first byte received is the LSB. After the 4th byte: go to WRITE.
- WRITE: imem_we=1 for exactly one cycle, with imem_addr = current word index and imem_wdata = packed word. in_ready=0. Then increment the word index. If index+1 == latched count, go to DONE; otherwise go to RECV.
- DONE: cpu_rst=0, done=1, in_ready=0. start re-enters the load sequence exactly as from IDLE, and cpu_rst reasserts on the same edge.
- start while busy is ignored.
- in_valid outside RECV is ignored. No byte is consumed.
- Word index wrap: the index is ADDR_W+1 bits wide, so a count of 2^ADDR_W terminates correctly. imem_addr is the low ADDR_W bits.

## Timing
- Reset values (async, while rst=0): state=IDLE, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0. Byte counter and word index are 0.
- Reset mid-load aborts immediately. Partial words are discarded. Memory writes already made are not undone.
- All outputs are registered; state changes occur on the rising clk edge.
- in_ready goes high the cycle after an accepted start.
- Minimum 4 cycles per byte-group, plus 1 WRITE cycle, so 5 cycles per word at full rate.
- imem_we asserts in the cycle after the 4th byte handshake.
- done=1 and cpu_rst=0 in the cycle after the final WRITE cycle.
- Back-pressure: the only stall is in_valid=0 in RECV. The loader holds state indefinitely with no timeout.

## Structure
- Shared package mips_loader_pkg holds:
  - the state enum (IDLE, RECV, WRITE, DONE);
  - BYTES_PER_WORD=4;
  - the reset value of cpu_rst.
- One sub-module: byte_packer.
  - Function: 2-bit byte counter plus 32-bit shift/packing register.
  - Ports: clk, rst, clr, shift_en, byte_in; outputs word_out, word_full.
- The top contains the FSM, word index, count latch and output registers.

## Test plan
- Reset then start with word_count=2, bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE at full rate -> expected response:
  - writes of 0x12345678 @0 and 0xDEADBEEF @1;
  - imem_we high exactly 2 cycles;
  - done=1, cpu_rst=0 one cycle after the second write.
- word_count=0 start -> DONE next cycle, no imem_we, cpu_rst=0.
- Same 2-word load with in_valid toggling 1/0 every cycle -> identical writes. in_ready never drops in RECV. Total time roughly doubles.
- Assert rst=0 after 6 bytes of a 2-word load -> expected response:
  - immediate IDLE with cpu_rst=1;
  - only word @0 was written;
  - a fresh start reloads from address 0.
- From DONE, start with word_count=1 and bytes 0x01..0x04 -> cpu_rst=1 on the start edge, write 0x04030201 @0, then done.
- ADDR_W=2, word_count=7 (clamped to 4), 16 bytes -> writes to addresses 0..3 only, then DONE. Extra in_valid is ignored with in_ready=0.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program loader.
package mips_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // The core is held in reset until a load has completed.
    localparam logic CPU_RST_RESET = 1'b1;

endpackage

// File: rtl/mips_program_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word_full flags that the slot about to be filled is the last one of the word,
// so a shift while word_full is high completes the word.
module byte_packer
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_full
);

    localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_cnt;
    logic [31:0] word_q;

    // Shift right so the first byte received ends up in bits [7:0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            word_q   <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
            word_q   <= '0;
        end else if (shift_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_q   <= {byte_in, word_q[31:8]};
        end
    end

    assign word_out  = word_q;
    assign word_full = (byte_cnt == LAST_SLOT);

endmodule

// File: rtl/mips_program_loader.sv
// Boot loader: receives a byte stream, writes packed words into instruction
// memory from address 0 and releases the MIPS core once the load completes.
//
// state | meaning
// IDLE  | after reset, core held in reset, waiting for start
// RECV  | accepting bytes of the current word
// WRITE | one-cycle instruction-memory write of the packed word
// DONE  | load complete, core released, start begins a new load
module mips_program_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   word_idx;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_clamped;
    logic              load_start;
    logic              handshake;
    logic              last_word;
    logic              word_full;

    assign handshake     = in_valid & in_ready;
    assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign load_start    = ((state == IDLE) || (state == DONE)) && start && (word_count != '0);
    assign last_word     = ((word_idx + ONE) == count_q);

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (load_start),
        .shift_en  (handshake),
        .byte_in   (in_data),
        .word_out  (imem_wdata),
        .word_full (word_full)
    );

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (word_count == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (handshake && word_full) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? DONE : RECV;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            imem_we  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cpu_rst  <= CPU_RST_RESET;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == RECV);
            imem_we  <= (state_next == WRITE);
            busy     <= (state_next == RECV) || (state_next == WRITE);
            done     <= (state_next == DONE);
            cpu_rst  <= (state_next != DONE);
        end
    end

    // Word index and latched word count; the index is one bit wider than the address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_idx <= '0;
            count_q  <= '0;
        end else if (load_start) begin
            word_idx <= '0;
            count_q  <= count_clamped;
        end else if (state == WRITE) begin
            word_idx <= word_idx + ONE;
        end
    end

    assign imem_addr = word_idx[ADDR_W-1:0];

endmodule
